// File: rtl/poly_synthesizer.sv
// Polyphonic square-wave synthesizer: debounced keys -> voice allocation -> sigma-delta speaker bit.
// Optional macro OCTAVE_SEL_EN adds octave[1:0], which right-shifts every voice half-period.
module poly_synthesizer #(
    parameter int unsigned NUM_KEYS     = 8,
    parameter int unsigned NUM_VOICES   = 4,
    parameter int unsigned DEBOUNCE_CYC = 59524,
    parameter int unsigned DIV_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_KEYS-1:0]   btn,
`ifdef OCTAVE_SEL_EN
    input  logic [1:0]            octave,
`endif
    output logic                  speaker,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  key_dropped
);

    localparam int unsigned KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned SUM_W = $clog2(NUM_VOICES + 1);
    localparam int unsigned ACC_W = $clog2(2 * NUM_VOICES);

    logic [1:0] oct_c;
`ifdef OCTAVE_SEL_EN
    assign oct_c = octave;
`else
    assign oct_c = 2'd0;
`endif

    // Half-period in cycles: base note, keys 8..15 one octave up, then octave shift.
    function automatic logic [DIV_W-1:0] half_period(input logic [KEY_W-1:0] key,
                                                     input logic [1:0]       oct);
        logic [3:0]  k4;
        logic [15:0] base;
        logic [2:0]  shift;
        k4 = 4'(key);
        case (k4[2:0])
            3'd0:    base = 16'd11376;
            3'd1:    base = 16'd10135;
            3'd2:    base = 16'd9029;
            3'd3:    base = 16'd8522;
            3'd4:    base = 16'd7592;
            3'd5:    base = 16'd6764;
            3'd6:    base = 16'd6026;
            default: base = 16'd5688;
        endcase
        shift = 3'(k4[3]) + 3'(oct);
        return DIV_W'(base >> shift);
    endfunction

    logic [NUM_KEYS-1:0]   sync1_q, sync2_q;
    logic [NUM_KEYS-1:0]   deb_q, deb_d, armed_q, armed_d;
    logic [DB_W-1:0]       db_cnt_q [NUM_KEYS];
    logic [DB_W-1:0]       db_cnt_d [NUM_KEYS];
    logic [NUM_VOICES-1:0] va_q, va_d, tone_q, tone_d;
    logic [KEY_W-1:0]      vkey_q [NUM_VOICES];
    logic [KEY_W-1:0]      vkey_d [NUM_VOICES];
    logic [DIV_W-1:0]      vcnt_q [NUM_VOICES];
    logic [DIV_W-1:0]      vcnt_d [NUM_VOICES];
    logic [DIV_W-1:0]      vhalf_q [NUM_VOICES];
    logic [DIV_W-1:0]      vhalf_d [NUM_VOICES];
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  spk_q, spk_d, drop_q, drop_d;

    logic [NUM_KEYS-1:0]   owned, pending;
    logic                  free_any, cand_any, held;
    logic [VID_W-1:0]      free_idx;
    logic [KEY_W-1:0]      cand_idx;
    logic [SUM_W-1:0]      sum;
    logic [ACC_W-1:0]      acc_n;

    always_comb begin
        deb_d    = deb_q;
        armed_d  = armed_q;
        db_cnt_d = db_cnt_q;
        va_d     = va_q;
        tone_d   = tone_q;
        vkey_d   = vkey_q;
        vcnt_d   = vcnt_q;
        vhalf_d  = vhalf_q;
        acc_d    = acc_q;
        spk_d    = 1'b0;
        drop_d   = 1'b0;
        owned    = '0;
        pending  = '0;
        free_any = 1'b0;
        free_idx = '0;
        cand_any = 1'b0;
        cand_idx = '0;
        held     = 1'b0;
        sum      = '0;
        acc_n    = '0;

        for (int k = 0; k < NUM_KEYS; k++)
            for (int v = 0; v < NUM_VOICES; v++)
                if (va_q[v] && vkey_q[v] == KEY_W'(k)) owned[k] = 1'b1;

        // Lowest free voice and lowest held-but-unowned key.
        for (int v = int'(NUM_VOICES) - 1; v >= 0; v--)
            if (!va_q[v]) begin
                free_any = 1'b1;
                free_idx = VID_W'(v);
            end
        for (int k = int'(NUM_KEYS) - 1; k >= 0; k--)
            if (deb_q[k] && !owned[k]) begin
                cand_any = 1'b1;
                cand_idx = KEY_W'(k);
            end

        for (int v = 0; v < NUM_VOICES; v++) begin
            held = 1'b0;
            for (int k = 0; k < NUM_KEYS; k++)
                if (vkey_q[v] == KEY_W'(k)) held = deb_q[k];
            if (va_q[v]) begin
                if (!held) begin
                    va_d[v]   = 1'b0;
                    tone_d[v] = 1'b0;
                    vcnt_d[v] = '0;
                end else if (vcnt_q[v] == vhalf_q[v] - DIV_W'(1)) begin
                    tone_d[v]  = ~tone_q[v];
                    vcnt_d[v]  = '0;
                    vhalf_d[v] = half_period(vkey_q[v], oct_c);
                end else begin
                    vcnt_d[v] = vcnt_q[v] + DIV_W'(1);
                end
            end else if (cand_any && free_any && free_idx == VID_W'(v)) begin
                va_d[v]    = 1'b1;
                tone_d[v]  = 1'b0;
                vkey_d[v]  = cand_idx;
                vcnt_d[v]  = '0;
                vhalf_d[v] = half_period(cand_idx, oct_c);
            end
        end

        // A freshly pressed key that cannot get a voice is reported once, then waits.
        pending = deb_q & ~owned & armed_q;
        if (|pending && !free_any) begin
            drop_d  = 1'b1;
            armed_d = armed_d & ~pending;
        end
        for (int k = 0; k < NUM_KEYS; k++)
            if (cand_any && free_any && cand_idx == KEY_W'(k)) armed_d[k] = 1'b0;

        for (int k = 0; k < NUM_KEYS; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_d[k]    = sync2_q[k];
                    armed_d[k]  = sync2_q[k];
                    db_cnt_d[k] = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end else begin
                db_cnt_d[k] = '0;
            end
        end

        // First-order sigma-delta of the count of high tones.
        for (int v = 0; v < NUM_VOICES; v++)
            sum = sum + SUM_W'(tone_q[v] & va_q[v]);
        acc_n = acc_q + ACC_W'(sum);
        if (acc_n >= ACC_W'(NUM_VOICES)) begin
            spk_d = 1'b1;
            acc_d = acc_n - ACC_W'(NUM_VOICES);
        end else begin
            acc_d = acc_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            armed_q <= '0;
            va_q    <= '0;
            tone_q  <= '0;
            acc_q   <= '0;
            spk_q   <= 1'b0;
            drop_q  <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vkey_q[v]  <= '0;
                vcnt_q[v]  <= '0;
                vhalf_q[v] <= '0;
            end
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            armed_q  <= armed_d;
            db_cnt_q <= db_cnt_d;
            va_q     <= va_d;
            tone_q   <= tone_d;
            vkey_q   <= vkey_d;
            vcnt_q   <= vcnt_d;
            vhalf_q  <= vhalf_d;
            acc_q    <= acc_d;
            spk_q    <= spk_d;
            drop_q   <= drop_d;
        end
    end

    assign speaker      = spk_q;
    assign voice_active = va_q;
    assign key_dropped  = drop_q;

endmodule

// File: tb/tb_poly_synthesizer.sv
// Bench for poly_synthesizer: timestamp-based reference model checked every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_poly_synthesizer;

    localparam int NK = 8;
    localparam int NV = 4;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn = 8'h00;
    logic       speaker;
    logic [3:0] voice_active;
    logic       key_dropped;
`ifdef OCTAVE_SEL_EN
    logic [1:0] octave = 2'd0;
`endif

    always #84 clk = ~clk;

    poly_synthesizer #(
        .NUM_KEYS(NK), .NUM_VOICES(NV), .DEBOUNCE_CYC(DB), .DIV_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
`ifdef OCTAVE_SEL_EN
        .octave(octave),
`endif
        .speaker(speaker),
        .voice_active(voice_active),
        .key_dropped(key_dropped)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each voice remembers when it was allocated; tone level follows from elapsed time.
    int      half_tab [8] = '{11376, 10135, 9029, 8522, 7592, 6764, 6026, 5688};
    bit [7:0] m_s1, m_s2, m_deb, m_armed, m_owned, m_pend, old_deb;
    int      m_run [NK];
    bit      m_on [NV];
    int      m_key [NV];
    longint  m_t0 [NV];
    int      m_h [NV];
    int      m_acc, m_sum, m_oct, m_cand, m_free;
    bit      m_spk, m_drop;
    longint  cyc;
    logic [3:0] m_va;

    function automatic bit tone_at(input int v, input longint t);
        if (!m_on[v]) return 1'b0;
        return ((t - m_t0[v]) / longint'(m_h[v])) % 2 == 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_armed = '0;
            m_acc = 0; m_spk = 0; m_drop = 0; cyc = 0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
            for (int v = 0; v < NV; v++) begin m_on[v] = 0; m_key[v] = 0; m_t0[v] = 0; m_h[v] = 1; end
        end else begin
            cyc = cyc + 1;
`ifdef OCTAVE_SEL_EN
            m_oct = int'(octave);
`else
            m_oct = 0;
`endif
            m_sum = 0;
            for (int v = 0; v < NV; v++) if (tone_at(v, cyc - 1)) m_sum++;
            if (m_acc + m_sum >= NV) begin m_spk = 1; m_acc = m_acc + m_sum - NV; end
            else begin m_spk = 0; m_acc = m_acc + m_sum; end

            old_deb = m_deb;
            m_owned = '0;
            for (int v = 0; v < NV; v++) if (m_on[v]) m_owned[m_key[v]] = 1'b1;
            m_free = -1;
            for (int v = NV - 1; v >= 0; v--) if (!m_on[v]) m_free = v;
            m_cand = -1;
            for (int k = NK - 1; k >= 0; k--) if (old_deb[k] && !m_owned[k]) m_cand = k;

            for (int v = 0; v < NV; v++) if (m_on[v] && !old_deb[m_key[v]]) m_on[v] = 0;
            m_drop = 0;
            if (m_free >= 0) begin
                if (m_cand >= 0) begin
                    m_on[m_free] = 1; m_key[m_free] = m_cand; m_t0[m_free] = cyc;
                    m_h[m_free] = (half_tab[m_cand % 8] >> (m_cand / 8)) >> m_oct;
                    m_armed[m_cand] = 0;
                end
            end else begin
                m_pend = old_deb & ~m_owned & m_armed;
                if (m_pend != 0) begin m_drop = 1; m_armed = m_armed & ~m_pend; end
            end

            // Debounce: accept a new level once it has persisted DB cycles in a row.
            for (int k = 0; k < NK; k++) begin
                if (m_s2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_deb[k] = m_s2[k]; m_armed[k] = m_s2[k]; m_run[k] = 0;
                    end
                end else m_run[k] = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    always @(negedge clk) begin
        for (int v = 0; v < NV; v++) m_va[v] = m_on[v];
        check("cyc_speaker", int'(speaker), int'(m_spk));
        check("cyc_voice_active", int'(voice_active), int'(m_va));
        check("cyc_key_dropped", int'(key_dropped), int'(m_drop));
    end

    int ones;
    int drops;

    initial begin
        rst_n = 1'b0;
        btn   = 8'hFF;
        repeat (5) @(negedge clk);
        check("rst_speaker", int'(speaker), 0);
        check("rst_voice_active", int'(voice_active), 0);
        btn = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_speaker", int'(speaker), 0);
        check("idle_voice_active", int'(voice_active), 0);

        // Bounce key 0 every 2 cycles for 40 cycles.
        for (int i = 0; i < 20; i++) begin
            btn = (i % 2 == 0) ? 8'h01 : 8'h00;
            repeat (2) @(negedge clk);
        end
        btn = 8'h00;
        repeat (10) @(negedge clk);
        check("bounce_voice_active", int'(voice_active), 0);

        // Single C4: allocation after 2+4+1 edges, then one low and one high half-period.
        btn = 8'h01;
        repeat (6) @(negedge clk);
        check("c4_before_alloc", int'(voice_active), 0);
        @(negedge clk);
        check("c4_alloc", int'(voice_active), 1);
        ones = 0;
        for (int i = 0; i < 2 * 11376 + 10; i++) begin
            @(negedge clk);
            ones += int'(speaker);
        end
        check("c4_density_ones", ones, 2844);
        btn = 8'h00;
        repeat (10) @(negedge clk);
        check("c4_release_va", int'(voice_active), 0);
        check("c4_release_speaker", int'(speaker), 0);

`ifdef OCTAVE_SEL_EN
        // A4 two octaves up: half-period 1691 cycles.
        octave = 2'd2;
        btn = 8'h20;
        repeat (7) @(negedge clk);
        check("oct_alloc", int'(voice_active), 1);
        ones = 0;
        for (int i = 0; i < 2 * 1691 + 10; i++) begin
            @(negedge clk);
            ones += int'(speaker);
        end
        check("oct_density_ones", ones, 422);
        btn = 8'h00;
        repeat (10) @(negedge clk);
        octave = 2'd0;
        check("oct_release_va", int'(voice_active), 0);
`endif

        // Five keys on four voices: one drop for key 4, then key 4 inherits voice 1.
        btn = 8'h1F;
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drops += int'(key_dropped);
        end
        check("five_drops", drops, 1);
        check("five_va", int'(voice_active), 15);
        btn = 8'h1D;
        drops = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drops += int'(key_dropped);
        end
        check("reuse_va", int'(voice_active), 15);
        check("reuse_no_drop", drops, 0);
        btn = 8'h00;
        repeat (15) @(negedge clk);
        check("five_release_va", int'(voice_active), 0);
        check("five_release_speaker", int'(speaker), 0);

        // Keys 0..3 together: all four tones high over a common window -> speaker solid 1.
        btn = 8'h0F;
        repeat (7) @(negedge clk);
        repeat (11400) @(negedge clk);
        check("chord_va", int'(voice_active), 15);
        ones = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            ones += int'(speaker);
        end
        check("chord_all_high_ones", ones, 5000);
        btn = 8'h00;
        repeat (15) @(negedge clk);
        check("chord_release_va", int'(voice_active), 0);
        check("chord_release_speaker", int'(speaker), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
